// File: rtl/pulse_period_meter.sv
// Measures the spacing in clocks between rising edges of i_pulse, range-checks
// each period against EXPECTED +/- TOL and flags loss of the tick as a timeout.
module pulse_period_meter #(
  parameter int W          = 20,
  parameter int MAX_PERIOD = 1000000,
  parameter int EXPECTED   = 416667,
  parameter int TOL        = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_pulse,
  output logic [W-1:0] o_period,
  output logic         o_valid,
  output logic         o_in_range,
  output logic         o_timeout,
  output logic         o_measuring
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam logic [W-1:0] MAX_W = W'(MAX_PERIOD);

  // Bounds at 64-bit width so EXPECTED+TOL cannot wrap; a negative low bound clamps to 0.
  localparam longint      LO_RAW = longint'(EXPECTED) - longint'(TOL);
  localparam longint      HI_RAW = longint'(EXPECTED) + longint'(TOL);
  localparam logic [63:0] LO     = (LO_RAW < 0) ? 64'd0 : 64'(LO_RAW);
  localparam logic [63:0] HI     = 64'(HI_RAW);

  logic [0:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_q;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         in_range_q, in_range_d;
  logic         timeout_q, timeout_d;

  logic         edge_w;
  logic [63:0]  cnt_ext;
  logic         in_range_w;

  assign edge_w     = i_pulse & ~pulse_q;
  assign cnt_ext    = 64'(cnt_q);
  assign in_range_w = (cnt_ext >= LO) && (cnt_ext <= HI);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (edge_w) begin
          cnt_d     = W'(1);
          state_d   = ST_MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        // An edge on the terminal count still wins over the timeout.
        if (edge_w) begin
          period_d   = cnt_q;
          valid_d    = 1'b1;
          in_range_d = in_range_w;
          cnt_d      = W'(1);
        end else if (cnt_q == MAX_W) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= i_pulse;
      period_q   <= period_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_period    = period_q;
  assign o_valid     = valid_q;
  assign o_in_range  = in_range_q;
  assign o_timeout   = timeout_q;
  assign o_measuring = (state_q == ST_MEASURE);

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Measures the spacing, in i_clk cycles, between rising edges of a periodic tick, such as the 120 Hz strobe from the prescaler.
- Reports each measured period with a one-cycle valid strobe and a range check against an expected value.
- Flags loss of the tick with a timeout.
- Sits downstream of tick generators as the checker and receiver of their strobes: lab self-test and clock-health monitoring.

Parameters:
- W, 20: width of the period counter and of o_period. Must satisfy 2^W-1 >= MAX_PERIOD.
- MAX_PERIOD, 1000000: longest accepted period in clocks. Waiting longer than this is a timeout.
- EXPECTED, 416667: nominal period in clocks (a prescaler with limit L produces L+1).
- TOL, 0: allowed absolute deviation from EXPECTED for o_in_range.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_pulse  input  1  tick input, synchronous to i_clk; any pulse width >= 1 cycle.
- o_period  output  W  last measured period in clocks; holds between measurements.
- o_valid  output  1  one-cycle strobe: o_period/o_in_range just updated.
- o_in_range  output  1  |o_period - EXPECTED| <= TOL; updated together with o_valid.
- o_timeout  output  1  level; tick lost (no edge within MAX_PERIOD clocks).
- o_measuring  output  1  high in MEASURE state.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE, cnt=0, pulse_d=0.
  - o_period=0, o_valid=0, o_in_range=0, o_timeout=0, o_measuring=0.
  - Reset mid-measurement discards the partial count; no valid is issued.
- Edge detect: edge = i_pulse & ~pulse_d, evaluated combinationally each cycle. pulse_d <= i_pulse every cycle.
  - A level held high counts once.
  - i_pulse already high on the first cycle after reset counts as an edge.
- State IDLE:
  - cnt holds 0.
  - On edge: cnt<=1, state<=MEASURE, o_timeout<=0. No o_valid, because the first edge only starts timing.
- State MEASURE (o_measuring=1):
  - No edge and cnt < MAX_PERIOD: cnt<=cnt+1.
  - Edge: o_period<=cnt, o_valid<=1, o_in_range<=(range check on cnt), cnt<=1, stay in MEASURE.
  - Edges N clocks apart yield o_period=N.
  - No edge and cnt == MAX_PERIOD: o_timeout<=1, cnt<=0, state<=IDLE. o_period and o_in_range hold; no o_valid.
  - Edge in the same cycle cnt == MAX_PERIOD: the edge wins. It is reported as period MAX_PERIOD, with no timeout.
- Timing:
  - o_valid is high exactly one cycle: the cycle after the edge was seen (one clock of latency).
  - o_valid is 0 in all other cycles.
- o_timeout:
  - Sticky until the next edge, which clears it and starts a new measurement.
  - The next valid arrives only after a further edge.
- Range check:
  - Computed without wrap: in range when EXPECTED-TOL <= cnt <= EXPECTED+TOL.
  - Bounds are evaluated at full integer width; a negative lower bound clamps to 0.
- Arithmetic: cnt is unsigned W bits and never wraps; it is bounded by MAX_PERIOD.
- Minimum period: edges 2 clocks apart are measured as 2. Back-to-back edges are impossible, because a rising edge needs a low cycle in between.

Test Plan (bench parameters W=8, MAX_PERIOD=20, EXPECTED=10, TOL=1):
1. Reset, then 1-cycle pulses every 10 clocks ×4.
   - No valid on the first edge.
   - Then 3 o_valid strobes, each one cycle after its edge: o_period=10, o_in_range=1, o_measuring=1.
2. Pulses spaced 10, 12, 9, 11.
   - o_period=12 with o_in_range=0.
   - 9 and 11 give o_in_range=1.
3. One edge, then i_pulse held low.
   - o_timeout=1 when cnt would pass 20; o_measuring=0; o_period holds its last value.
   - Next edge clears o_timeout with no valid. A following edge 10 later gives o_period=10.
4. Edges exactly 20 apart: o_period=20, o_valid=1, o_timeout stays 0. Edges 21 apart: timeout, no valid.
5. Pulse held high 5 cycles with period 10: counted as one edge per period, o_period=10. Minimum spacing (high, low, high) gives o_period=2.
6. Assert i_reset mid-count (cnt≈7), release.
   - All outputs are 0 immediately (asynchronous).
   - The first post-reset edge produces no valid.
   - Normal measurement resumes.
